axi_r_burst_tagger: RTL and testbench
=====================================

Name: axi_r_burst_tagger

Overview:
- Consumer side of the {id, len} burst-tracking queue used by the AXI memory adapters.
- Accepts read commands (AR id + len), queues them, then receives untagged data beats from a memory backend.
- Tags each beat with the head command's ID, generates rlast from a per-burst beat counter, and presents a registered AXI R channel.

Parameters:
- AxiIdWidth, 4, width of AXI ID.
- LenWidth, 8, AXI len width (beats-1), taken from the shared axi package.
- DataWidth, 32, R data width.
- CmdDepth, 4, command queue depth (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- flush_i  in  1  synchronous clear of queue, counter and output stage.
- cmd_id_i  in  AxiIdWidth  command ID.
- cmd_len_i  in  LenWidth  command burst length minus 1.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- beat_data_i  in  DataWidth  backend data beat.
- beat_err_i  in  1  backend error for this beat.
- beat_valid_i  in  1  beat valid.
- beat_ready_o  out  1  beat accepted when valid&ready.
- r_id_o  out  AxiIdWidth  R ID.
- r_data_o  out  DataWidth  R data.
- r_resp_o  out  2  R response.
- r_last_o  out  1  R last.
- r_valid_o  out  1  R valid.
- r_ready_i  in  1  R ready.
- busy_o  out  1  queue non-empty or r_valid_o high.

Behaviour:
- Reset values: r_valid_o=0; r_id_o, r_data_o, r_resp_o, r_last_o = 0; beat counter = 0; queue empty.
- cmd_ready_o = ~queue_full. There is no bypass: a pop in the same cycle does not free a slot until the next cycle.
- Queue entries are packed {id, len}. The queue is non-fall-through, so a command accepted in cycle N can tag beats from cycle N+1.
- beat_ready_o = ~queue_empty & (~r_valid_o | r_ready_i). Beats arriving with no command queued stall and are never dropped.
- On beat handshake, next cycle:
  - r_valid_o=1.
  - r_data_o=beat_data_i.
  - r_id_o=head.id.
  - r_resp_o = beat_err_i ? 2'b10 (SLVERR) : 2'b00 (OKAY).
  - r_last_o = (cnt_q == head.len).
- Latency from beat handshake to R valid is exactly 1 cycle. Full throughput: 1 beat per cycle while r_ready_i=1.
- Counter update on a beat handshake:
  - If last: pop the queue and set cnt_q to 0.
  - Otherwise: cnt_q+1.
  - cnt_q is LenWidth bits wide; len=255 produces 256 beats with no overflow.
- Error beats do not terminate a burst; the beat count is always len+1.
- Output stage: if r_valid_o & ~r_ready_i, all R outputs hold stable. If r_valid_o & r_ready_i with no new beat, r_valid_o drops next cycle.
- Simultaneous events:
  - Command push and last-beat pop in the same cycle: both take effect.
  - Command push with an empty queue while a beat is waiting: the beat is accepted the following cycle.
- flush_i (priority over all handshakes):
  - Queue empty, cnt_q=0, r_valid_o=0 next cycle.
  - cmd_ready_o and beat_ready_o are forced 0 during the flush cycle.
  - Use only when the R consumer tolerates a dropped beat.
- Reset mid-burst: all state returns to reset values immediately (asynchronous).

Decomposition:
- Shared package:
  - LenWidth.
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants.
  - Packed cmd entry typedef {id, len}.
- Sub-module: the codebase's fifo_v3, instantiated as the command queue with FALL_THROUGH=0 and DEPTH=CmdDepth.
- The counter and R output register stay in this module.

Test Plan:
1. Reset, then cmd id=3 len=0; one beat 0xA5A5A5A5 -> one cycle later R id=3, data=0xA5A5A5A5, resp=00, last=1; busy_o=0 after handshake.
2. cmd id=1 len=3; 4 back-to-back beats with r_ready_i=1 -> 4 R beats on consecutive cycles, id=1, last only on the 4th; queue empties.
3. CmdDepth=4: push 5 commands with no beats -> cmd_ready_o=0 after 4 accepted. Drive a 1-beat burst; cmd_ready_o returns 1 the cycle after pop, not during it.
4. Beats offered with empty queue for 5 cycles -> beat_ready_o=0 throughout. Push cmd id=7 len=1 -> first beat accepted the next cycle.
5. r_ready_i=0 for 3 cycles mid-burst -> R outputs stable, beat_ready_o=0. Release: beats resume without loss; 2nd beat has beat_err_i=1 -> resp=10, burst still len+1 beats.
6. cmd len=255 -> 256 beats, last only on beat 256. Assert flush_i mid-burst -> queue empty, r_valid_o=0 next cycle, cnt restarts at 0 for the next cmd.

Source files
------------

// File: rtl/axi_r_burst_tagger_pkg.sv
// Shared types and constants for the AXI R burst tagger.
// Command entries pair an AXI ID with the burst length field.
package axi_r_burst_tagger_pkg;

  localparam int unsigned AxiLenWidth = 8;
  localparam int unsigned AxiIdWidthDef = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AxiIdWidthDef-1:0] id;
    logic [AxiLenWidth-1:0]   len;
  } cmd_entry_t;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with optional fall-through and synchronous flush.
// Used as the command queue in the R burst tagger.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]      rd_q, wr_q;
  logic [CntW-1:0]       cnt_q;
  logic                  bypass, do_push, do_pop;

  function automatic logic [AddrW-1:0] nxt(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full_o  = (cnt_q == CntW'(DEPTH));
    empty_o = (cnt_q == '0);
    data_o  = mem_q[rd_q];
    bypass  = 1'b0;
    // Fall-through: an empty queue forwards the pushed word directly
    if (FALL_THROUGH && empty_o && push_i) begin
      empty_o = 1'b0;
      data_o  = data_i;
      bypass  = pop_i;
    end
    do_push = push_i & ~full_o & ~bypass;
    do_pop  = pop_i & ~empty_o & ~bypass;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/axi_r_burst_tagger.sv
// Queues AR {id, len} commands and tags backend data beats with the
// head command's ID, generating rlast into a registered R channel.
module axi_r_burst_tagger
  import axi_r_burst_tagger_pkg::*;
#(
  parameter int unsigned AxiIdWidth = 4,
  parameter int unsigned LenWidth   = AxiLenWidth,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned CmdDepth   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [AxiIdWidth-1:0] cmd_id_i,
  input  logic [LenWidth-1:0]   cmd_len_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [DataWidth-1:0]  beat_data_i,
  input  logic                  beat_err_i,
  input  logic                  beat_valid_i,
  output logic                  beat_ready_o,
  output logic [AxiIdWidth-1:0] r_id_o,
  output logic [DataWidth-1:0]  r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic                  busy_o
);

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [LenWidth-1:0]   len;
  } cmd_t;

  cmd_t                head, cmd_in;
  logic                q_full, q_empty;
  logic                cmd_push, cmd_pop;
  logic                beat_hs, is_last;
  logic [LenWidth-1:0] cnt_q;

  assign cmd_in       = '{id: cmd_id_i, len: cmd_len_i};
  assign cmd_ready_o  = ~q_full & ~flush_i;
  assign cmd_push     = cmd_valid_i & cmd_ready_o;
  assign beat_ready_o = ~q_empty & (~r_valid_o | r_ready_i) & ~flush_i;
  assign beat_hs      = beat_valid_i & beat_ready_o;
  assign is_last      = (cnt_q == head.len);
  assign cmd_pop      = beat_hs & is_last;
  assign busy_o       = ~q_empty | r_valid_o;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   ($bits(cmd_t)),
    .DEPTH        (CmdDepth)
  ) u_cmd_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (cmd_push),
    .pop_i   (cmd_pop),
    .data_i  (cmd_in),
    .full_o  (q_full),
    .empty_o (q_empty),
    .data_o  (head)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (beat_hs) begin
      cnt_q <= is_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_id_o    <= '0;
      r_data_o  <= '0;
      r_resp_o  <= RESP_OKAY;
      r_last_o  <= 1'b0;
    end else if (flush_i) begin
      r_valid_o <= 1'b0;
      r_id_o    <= '0;
      r_data_o  <= '0;
      r_resp_o  <= RESP_OKAY;
      r_last_o  <= 1'b0;
    end else if (beat_hs) begin
      r_valid_o <= 1'b1;
      r_id_o    <= head.id;
      r_data_o  <= beat_data_i;
      r_resp_o  <= beat_err_i ? RESP_SLVERR : RESP_OKAY;
      r_last_o  <= is_last;
    end else if (r_ready_i) begin
      r_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_r_burst_tagger.sv
// Self-checking bench for axi_r_burst_tagger: vector table, directed
// corner sequences and a randomized run against a queue-based model.
module tb_axi_r_burst_tagger;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush;
  logic [3:0]  cmd_id;
  logic [7:0]  cmd_len;
  logic        cmd_valid, cmd_ready;
  logic [31:0] beat_data;
  logic        beat_err, beat_valid, beat_ready;
  logic [3:0]  r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last, r_valid, r_ready, busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_r_burst_tagger #(
    .AxiIdWidth (4),
    .LenWidth   (8),
    .DataWidth  (32),
    .CmdDepth   (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .flush_i      (flush),
    .cmd_id_i     (cmd_id),
    .cmd_len_i    (cmd_len),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .beat_data_i  (beat_data),
    .beat_err_i   (beat_err),
    .beat_valid_i (beat_valid),
    .beat_ready_o (beat_ready),
    .r_id_o       (r_id),
    .r_data_o     (r_data),
    .r_resp_o     (r_resp),
    .r_last_o     (r_last),
    .r_valid_o    (r_valid),
    .r_ready_i    (r_ready),
    .busy_o       (busy)
  );

  typedef struct {
    logic        cv;
    logic [3:0]  id;
    logic [7:0]  len;
    logic        bv;
    logic [31:0] data;
    logic        err;
    logic        rr;
    logic        e_cr;
    logic        e_br;
    logic        e_rv;
    logic [3:0]  e_id;
    logic [31:0] e_data;
    logic [1:0]  e_resp;
    logic        e_last;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];
  vec_t v;

  typedef struct {
    int id;
    int len;
  } mcmd_t;

  mcmd_t       mq[$];
  int          mpos;
  bit          mrv;
  logic [3:0]  m_id;
  logic [31:0] m_data;
  logic [1:0]  m_resp;
  bit          m_last;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic drv(input logic cv, input logic [3:0] id,
                     input logic [7:0] len, input logic bv,
                     input logic [31:0] data, input logic err,
                     input logic rr, input logic fl);
    cmd_valid  = cv;
    cmd_id     = id;
    cmd_len    = len;
    beat_valid = bv;
    beat_data  = data;
    beat_err   = err;
    r_ready    = rr;
    flush      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  int n_last, last_pos;
  bit id_ok;
  logic        cv_r, bv_r, err_r, rr_r, fl_r;
  logic [3:0]  id_r;
  logic [7:0]  len_r;
  logic [31:0] data_r;
  bit e_cr, e_br, c_hs, b_hs;

  initial begin
    idle();
    #12;
    chk("rst_rvalid", r_valid, 0);
    chk("rst_rid", r_id, 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_rresp", r_resp, 0);
    chk("rst_rlast", r_last, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();

    vq.push_back('{1,3,0, 0,0,0, 1, 1,0, 0,0,0,0,0, 1});
    vq.push_back('{0,0,0, 1,32'hA5A5A5A5,0, 1, 1,1,
                   1,3,32'hA5A5A5A5,0,1, 1});
    vq.push_back('{0,0,0, 0,0,0, 1, 1,0, 0,0,0,0,0, 0});
    for (int i = 0; i < 5; i++)
      vq.push_back('{0,0,0, 1,32'h11111111,0, 1, 1,0, 0,0,0,0,0, 0});
    vq.push_back('{1,7,1, 1,32'h11111111,0, 1, 1,0, 0,0,0,0,0, 1});
    vq.push_back('{0,0,0, 1,32'h22222222,0, 1, 1,1,
                   1,7,32'h22222222,0,0, 1});
    vq.push_back('{0,0,0, 1,32'h33333333,1, 1, 1,1,
                   1,7,32'h33333333,2,1, 1});
    vq.push_back('{0,0,0, 0,0,0, 1, 1,0, 0,0,0,0,0, 0});
    vq.push_back('{1,5,2, 0,0,0, 1, 1,0, 0,0,0,0,0, 1});
    vq.push_back('{0,0,0, 1,32'hB0,0, 1, 1,1, 1,5,32'hB0,0,0, 1});
    for (int i = 0; i < 3; i++)
      vq.push_back('{0,0,0, 1,32'hB1,1, 0, 1,0, 1,5,32'hB0,0,0, 1});
    vq.push_back('{0,0,0, 1,32'hB1,1, 1, 1,1, 1,5,32'hB1,2,0, 1});
    vq.push_back('{0,0,0, 1,32'hB2,0, 1, 1,1, 1,5,32'hB2,0,1, 1});
    vq.push_back('{0,0,0, 0,0,0, 1, 1,0, 0,0,0,0,0, 0});

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      drv(v.cv, v.id, v.len, v.bv, v.data, v.err, v.rr, 0);
      #1;
      chk($sformatf("vec%0d_cmd_ready", i), cmd_ready, v.e_cr);
      chk($sformatf("vec%0d_beat_ready", i), beat_ready, v.e_br);
      tick();
      chk($sformatf("vec%0d_rvalid", i), r_valid, v.e_rv);
      chk($sformatf("vec%0d_busy", i), busy, v.e_busy);
      if (v.e_rv) begin
        chk($sformatf("vec%0d_rid", i), r_id, v.e_id);
        chk($sformatf("vec%0d_rdata", i), r_data, v.e_data);
        chk($sformatf("vec%0d_rresp", i), r_resp, v.e_resp);
        chk($sformatf("vec%0d_rlast", i), r_last, v.e_last);
      end
    end

    drv(1, 1, 3, 0, 0, 0, 1, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drv(0, 0, 0, 1, 32'hC0 + k, 0, 1, 0);
      tick();
      chk("b2b_rvalid", r_valid, 1);
      chk("b2b_rid", r_id, 1);
      chk("b2b_rdata", r_data, 32'hC0 + k);
      chk("b2b_rlast", r_last, (k == 3) ? 1 : 0);
    end
    idle();
    tick();
    chk("b2b_busy_end", busy, 0);

    for (int i = 0; i < 5; i++) begin
      drv(1, 4'(i), 0, 0, 0, 0, 1, 0);
      #1;
      chk($sformatf("fill%0d_cmd_ready", i), cmd_ready, (i < 4) ? 1 : 0);
      tick();
    end
    drv(0, 0, 0, 1, 32'hD0, 0, 1, 0);
    #1;
    chk("full_pop_cmd_ready", cmd_ready, 0);
    chk("full_pop_beat_ready", beat_ready, 1);
    tick();
    chk("after_pop_cmd_ready", cmd_ready, 1);
    chk("after_pop_rid", r_id, 0);
    chk("after_pop_rlast", r_last, 1);
    drv(1, 9, 0, 1, 32'hD1, 0, 1, 1);
    #1;
    chk("flush_cmd_ready", cmd_ready, 0);
    chk("flush_beat_ready", beat_ready, 0);
    tick();
    chk("flush_rvalid", r_valid, 0);
    chk("flush_busy", busy, 0);

    drv(1, 9, 255, 0, 0, 0, 1, 0);
    tick();
    n_last = 0;
    last_pos = -1;
    id_ok = 1;
    for (int k = 0; k < 256; k++) begin
      drv(0, 0, 0, 1, 32'(k), 0, 1, 0);
      tick();
      if (r_valid !== 1'b1 || r_id !== 4'd9 || r_data !== 32'(k))
        id_ok = 0;
      if (r_last === 1'b1) begin
        n_last++;
        last_pos = k;
      end
    end
    chk("len255_beats_ok", 32'(id_ok), 1);
    chk("len255_n_last", n_last, 1);
    chk("len255_last_pos", last_pos, 255);
    idle();
    tick();
    chk("len255_busy_end", busy, 0);

    drv(1, 4, 255, 0, 0, 0, 1, 0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drv(0, 0, 0, 1, 32'(k), 0, 1, 0);
      tick();
    end
    drv(0, 0, 0, 1, 32'hEE, 0, 1, 1);
    #1;
    chk("midflush_beat_ready", beat_ready, 0);
    tick();
    chk("midflush_rvalid", r_valid, 0);
    chk("midflush_busy", busy, 0);
    drv(1, 2, 1, 0, 0, 0, 1, 0);
    tick();
    drv(0, 0, 0, 1, 32'hF0, 0, 1, 0);
    tick();
    chk("postflush_b0_rlast", r_last, 0);
    chk("postflush_b0_rid", r_id, 2);
    drv(0, 0, 0, 1, 32'hF1, 0, 1, 0);
    tick();
    chk("postflush_b1_rlast", r_last, 1);

    drv(1, 8, 3, 0, 0, 0, 1, 0);
    tick();
    drv(0, 0, 0, 1, 32'h77, 0, 0, 0);
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_rvalid", r_valid, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    drv(1, 6, 0, 0, 0, 0, 1, 0);
    tick();
    drv(0, 0, 0, 1, 32'h66, 0, 1, 0);
    tick();
    chk("post_rst_rid", r_id, 6);
    chk("post_rst_rlast", r_last, 1);
    idle();
    tick();

    mq.delete();
    mrv = 0;
    mpos = 0;
    for (int c = 0; c < 3000; c++) begin
      cv_r   = 1'($urandom_range(0, 1));
      id_r   = 4'($urandom);
      len_r  = 8'($urandom_range(0, 3));
      bv_r   = ($urandom % 4) != 0;
      data_r = $urandom;
      err_r  = ($urandom % 5) == 0;
      rr_r   = ($urandom % 4) != 0;
      fl_r   = ($urandom % 60) == 0;
      drv(cv_r, id_r, len_r, bv_r, data_r, err_r, rr_r, fl_r);
      #1;
      e_cr = !fl_r && mq.size() < 4;
      e_br = !fl_r && mq.size() > 0 && (!mrv || rr_r);
      chk("rnd_cmd_ready", cmd_ready, e_cr);
      chk("rnd_beat_ready", beat_ready, e_br);
      c_hs = cv_r && e_cr;
      b_hs = bv_r && e_br;
      if (fl_r) begin
        mq.delete();
        mpos = 0;
        mrv = 0;
      end else begin
        if (b_hs) begin
          m_id   = 4'(mq[0].id);
          m_data = data_r;
          m_resp = err_r ? 2'b10 : 2'b00;
          m_last = (mpos == mq[0].len);
          mrv    = 1;
          if (m_last) begin
            void'(mq.pop_front());
            mpos = 0;
          end else begin
            mpos++;
          end
        end else if (rr_r) begin
          mrv = 0;
        end
        if (c_hs) mq.push_back('{int'(id_r), int'(len_r)});
      end
      tick();
      chk("rnd_rvalid", r_valid, mrv);
      chk("rnd_busy", busy, (mq.size() > 0 || mrv) ? 1 : 0);
      if (mrv) begin
        chk("rnd_rid", r_id, m_id);
        chk("rnd_rdata", r_data, m_data);
        chk("rnd_rresp", r_resp, m_resp);
        chk("rnd_rlast", r_last, m_last);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
